cache_controller: RTL and testbench

Direct-mapped, blocking, write-through cache controller sitting between the CPU data port and main memory. It produces the `cache_ready` signal that the hazard unit turns into the global pipeline stall. Read hits complete in the request cycle. Read misses fill the line from memory, and every write is sent through to memory, with `cache_ready` held low until the access can retire.

---
 rtl/cache_controller.sv | 114 +++++++++++
 tb/tb_cache_controller.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// Direct-mapped, blocking, write-through cache controller between the CPU data port and memory.
// Read hits retire combinationally; misses fill from memory; every write goes through to memory.
module cache_controller #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int INDEX_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cache_ready,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
);

  localparam int LINES    = 2 ** INDEX_BITS;
  localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, WDONE} state_t;

  state_t                state_reg;
  logic [LINES-1:0]      valid_reg;
  logic [TAG_BITS-1:0]   tag_mem  [LINES];
  logic [DATA_WIDTH-1:0] data_mem [LINES];

  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;
  logic                  hit;
  logic                  unused_addr_bits;

  assign index            = cpu_addr[INDEX_BITS+1:2];
  assign tag              = cpu_addr[ADDR_WIDTH-1:INDEX_BITS+2];
  assign hit              = valid_reg[index] && (tag_mem[index] == tag);
  assign unused_addr_bits = ^cpu_addr[1:0];

  // Ready/read data must be combinational so a read hit retires in its request cycle.
  always_comb begin
    cache_ready = 1'b0;
    cpu_rdata   = '0;
    if (!rst) begin
      case (state_reg)
        IDLE: begin
          if (!cpu_req) begin
            cache_ready = 1'b1;
          end else if (!cpu_we && hit) begin
            cache_ready = 1'b1;
            cpu_rdata   = data_mem[index];
          end
        end
        WDONE:   cache_ready = 1'b1;
        default: cache_ready = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // Reset wins over a coincident mem_ack: the in-flight transaction is dropped.
      state_reg <= IDLE;
      valid_reg <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cpu_req && (cpu_we || !hit)) begin
            mem_req   <= 1'b1;
            mem_we    <= cpu_we;
            mem_addr  <= {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
            if (cpu_we) begin
              mem_wdata <= cpu_wdata;
            end
            state_reg <= cpu_we ? WRITE : FILL;
          end
        end
        FILL: begin
          if (mem_ack) begin
            valid_reg[index] <= 1'b1;
            tag_mem[index]   <= tag;
            data_mem[index]  <= mem_rdata;
            mem_req          <= 1'b0;
            state_reg        <= IDLE;
          end
        end
        WRITE: begin
          if (mem_ack) begin
            // No write-allocate: only a line already holding this address is updated.
            if (hit) begin
              data_mem[index] <= cpu_wdata;
            end
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            state_reg <= WDONE;
          end
        end
        WDONE: begin
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench for cache_controller: a reference cache model predicts latency and data per access.
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cache_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] rdata;
    int          stalls;
  } exp_t;

  exp_t sb[$];

  logic        m_valid [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_data  [16];

  always #5 clk = ~clk;

  cache_controller #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .INDEX_BITS(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cache_ready(cache_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endtask

  // One blocking CPU access; k is the cycle (relative to the request cycle) in which memory acks.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input int k, input logic [31:0] fill);
    int          idx;
    logic [25:0] tg;
    logic        hit;
    logic        mem_seen;
    logic        done;
    int          c;
    exp_t        e;
    idx      = int'(addr[5:2]);
    tg       = addr[31:6];
    hit      = m_valid[idx] && (m_tag[idx] == tg);
    e.stalls = (!we && hit) ? 0 : k + 1;
    e.rdata  = we ? 32'h0 : (hit ? m_data[idx] : fill);
    sb.push_back(e);

    @(posedge clk); #1;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wd;
    mem_rdata = fill;
    mem_ack   = 1'b0;
    mem_seen  = 1'b0;
    done      = 1'b0;
    c         = 0;
    while (!done && c < 40) begin
      @(negedge clk);
      if (mem_req && !mem_seen) begin
        mem_seen = 1'b1;
        check("req_cycle", c, 1);
        check("mem_addr", mem_addr, {addr[31:2], 2'b00});
        check("mem_we", {31'b0, mem_we}, {31'b0, we});
        if (we) check("mem_wdata", mem_wdata, wd);
      end
      if (cache_ready) begin
        e = sb.pop_front();
        check("stalls", c, e.stalls);
        check("rdata", cpu_rdata, e.rdata);
        check("mem_used", {31'b0, mem_seen}, {31'b0, ~(~we & hit)});
        check("retire_memreq", {31'b0, mem_req}, 32'h0);
        done = 1'b1;
      end else begin
        @(posedge clk); #1;
        c++;
        mem_ack = (c == k);
      end
    end
    if (!done) begin
      check("timeout", 32'h0, 32'h1);
      void'(sb.pop_front());
    end
    $display("txn we=%0b addr=%h wdata=%h rdata=%h stalls=%0d hit=%0b", we, addr, wd, cpu_rdata, c, hit);

    if (!we && !hit) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      m_data[idx]  = fill;
    end else if (we && hit) begin
      m_data[idx] = wd;
    end

    @(posedge clk); #1;
    cpu_req = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);
    check("idle_ready", {31'b0, cache_ready}, 32'h1);
    check("idle_memreq", {31'b0, mem_req}, 32'h0);
    check("idle_rdata", cpu_rdata, 32'h0);
  endtask

  initial begin
    rst       = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    mem_rdata = '0;
    mem_ack   = 1'b0;
    model_clear();

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'b0, cache_ready}, 32'h0);
    check("rst_rdata", cpu_rdata, 32'h0);
    check("rst_memreq", {31'b0, mem_req}, 32'h0);
    check("rst_memaddr", mem_addr, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    access(1'b0, 32'h0000_0040, 32'h0, 3, 32'hDEAD_BEEF);
    access(1'b0, 32'h0000_0040, 32'h0, 3, 32'h0);
    access(1'b1, 32'h0000_0040, 32'h1234_5678, 1, 32'h0);
    access(1'b0, 32'h0000_0040, 32'h0, 2, 32'h0);
    access(1'b1, 32'h0000_0080, 32'hAAAA_5555, 2, 32'h0);
    access(1'b0, 32'h0000_0040, 32'h0, 2, 32'h0);
    access(1'b0, 32'h0000_0080, 32'h0, 2, 32'hAAAA_5555);
    access(1'b0, 32'h0000_0040, 32'h0, 1, 32'h1234_5678);
    access(1'b0, 32'h0000_0440, 32'h0, 2, 32'hC0FF_EE00);
    access(1'b0, 32'h0000_0040, 32'h0, 4, 32'h1234_5678);
    access(1'b0, 32'h0000_0044, 32'h0, 1, 32'h4444_0001);
    access(1'b0, 32'h0000_0047, 32'h0, 1, 32'h0);
    access(1'b1, 32'h0000_0047, 32'h5A5A_A5A5, 3, 32'h0);
    access(1'b0, 32'h0000_0044, 32'h0, 1, 32'h0);

    // Reset in the FILL cycle together with mem_ack.
    @(posedge clk); #1;
    cpu_req   = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = 32'h0000_0100;
    mem_rdata = 32'h0BAD_0BAD;
    @(posedge clk); #1;
    rst     = 1'b1;
    mem_ack = 1'b1;
    @(negedge clk);
    check("rstfill_ready", {31'b0, cache_ready}, 32'h0);
    check("rstfill_rdata", cpu_rdata, 32'h0);
    @(posedge clk); #1;
    rst     = 1'b0;
    mem_ack = 1'b0;
    cpu_req = 1'b0;
    @(negedge clk);
    check("rstfill_memreq", {31'b0, mem_req}, 32'h0);
    check("rstfill_idle", {31'b0, cache_ready}, 32'h1);
    $display("txn reset during fill addr=00000100");
    model_clear();

    access(1'b0, 32'h0000_0100, 32'h0, 2, 32'h55AA_55AA);
    access(1'b0, 32'h0000_0100, 32'h0, 2, 32'h0);
    access(1'b0, 32'h0000_0044, 32'h0, 1, 32'h4444_0002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
